// File: rtl/canvas_port_arbiter.sv
// Single-port canvas RAM arbiter: clear sequencer > stroke writer > read-out scanner.
// Define CANVAS_ARB_STARVE_GUARD_EN to force a scan read after STARVE_LIMIT lost cycles.
module canvas_port_arbiter #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              clear_busy,
    input  logic              draw_valid,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic              draw_data,
    output logic              draw_ready,
    input  logic              scan_start,
    output logic              scan_busy,
    output logic              scan_valid,
    output logic [ADDR_W-1:0] scan_addr,
    output logic              scan_data,
    output logic              scan_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_wdata,
    input  logic              mem_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    typedef enum logic {C_IDLE, C_RUN} c_state_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} s_state_t;

    c_state_t          c_state;
    s_state_t          s_state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] scan_ptr;
    logic              clear_own;
    logic              forced;
    logic              scan_grant;

    assign clear_own = (c_state == C_RUN);

`ifdef CANVAS_ARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt;

    assign forced = !clear_own && (s_state == S_RUN) && (starve_cnt == STARVE_MAX);

    // Counts consecutive cycles a running scan lost the port to draw; clear cycles freeze it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if ((s_state == S_RUN) && !clear_own) begin
            if (scan_grant) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end
`else
    assign forced = 1'b0;
`endif

    // Port mux and grants, fixed priority.
    always_comb begin
        draw_ready = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = 1'b0;
        scan_grant = 1'b0;
        if (!rst) begin
            if (clear_own) begin
                mem_addr = clr_cnt;
                mem_we   = 1'b1;
            end else if (forced) begin
                mem_addr   = scan_ptr;
                scan_grant = 1'b1;
            end else begin
                draw_ready = 1'b1;
                if (draw_valid) begin
                    mem_addr  = draw_addr;
                    mem_we    = 1'b1;
                    mem_wdata = draw_data;
                end else begin
                    mem_addr   = scan_ptr;
                    scan_grant = (s_state == S_RUN);
                end
            end
        end
    end

    // Clear sequencer: writes zeros from the top address down to 0; a new request restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_state    <= C_IDLE;
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
        end else begin
            case (c_state)
                C_IDLE: begin
                    if (clear_req) begin
                        c_state    <= C_RUN;
                        clr_cnt    <= ADDR_MAX;
                        clear_busy <= 1'b1;
                    end
                end
                C_RUN: begin
                    if (clear_req) begin
                        clr_cnt <= ADDR_MAX;
                    end else begin
                        clr_cnt <= clr_cnt - ADDR_W'(1);
                        if (clr_cnt == '0) begin
                            c_state    <= C_IDLE;
                            clear_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    c_state    <= C_IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

    // Scanner: one read per granted cycle, data presented the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_state    <= S_IDLE;
            scan_ptr   <= '0;
            scan_busy  <= 1'b0;
            scan_valid <= 1'b0;
            scan_done  <= 1'b0;
            scan_addr  <= '0;
        end else begin
            scan_valid <= scan_grant;
            scan_done  <= scan_grant && (scan_ptr == ADDR_MAX);
            if (scan_grant) begin
                scan_addr <= scan_ptr;
                scan_ptr  <= scan_ptr + ADDR_W'(1);
            end
            case (s_state)
                S_IDLE: begin
                    if (scan_start) begin
                        s_state   <= S_RUN;
                        scan_ptr  <= '0;
                        scan_busy <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (scan_grant && (scan_ptr == ADDR_MAX)) begin
                        s_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    s_state   <= S_IDLE;
                    scan_busy <= 1'b0;
                end
                default: begin
                    s_state   <= S_IDLE;
                    scan_busy <= 1'b0;
                end
            endcase
        end
    end

    // RAM output is already registered; mask it outside valid beats.
    assign scan_data = scan_valid & mem_rdata;

endmodule

// File: tb/tb_canvas_port_arbiter.sv
// Self-checking bench for canvas_port_arbiter: directed scenarios plus random traffic
// against a transaction-level model of the canvas and the three users.
module tb_canvas_port_arbiter;

    localparam int N     = 1024;
    localparam int LIMIT = 64;
`ifdef CANVAS_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_req = 1'b0;
    logic       draw_valid = 1'b0;
    logic [9:0] draw_addr = '0;
    logic       draw_data = 1'b0;
    logic       scan_start = 1'b0;
    logic       mem_rdata = 1'b0;
    logic       clear_busy, draw_ready, scan_busy, scan_valid, scan_data, scan_done;
    logic       mem_we, mem_wdata;
    logic [9:0] scan_addr, mem_addr;

    canvas_port_arbiter #(.ADDR_W(10), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .clear_req(clear_req), .clear_busy(clear_busy),
        .draw_valid(draw_valid), .draw_addr(draw_addr), .draw_data(draw_data),
        .draw_ready(draw_ready),
        .scan_start(scan_start), .scan_busy(scan_busy), .scan_valid(scan_valid),
        .scan_addr(scan_addr), .scan_data(scan_data), .scan_done(scan_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Canvas RAM with registered read, preloaded with random content.
    bit ram [N];
    initial begin
        for (int i = 0; i < N; i++) ram[i] = 1'($urandom_range(0, 1));
        forever begin
            @(posedge clk);
            mem_rdata <= ram[mem_addr];
            if (mem_we) ram[mem_addr] <= mem_wdata;
        end
    end

    int checks = 0;
    int failures = 0;

    // Reference model: canvas contents plus progress counters of each user.
    bit gold [N];
    int m_clr_left = 0;   // clear cycles still to run, 0 when no clear
    int m_phase = 0;      // 0 idle, 1 reading, 2 waiting for last beat
    int m_ptr = 0;
    int m_starve = 0;
    bit m_pend = 0;
    int m_pend_addr = 0;
    bit m_pend_data = 0;
    bit last_accept = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit clearing, forced, grant, e_rdy, e_we, e_wd;
        int e_addr;
        #1;
        clearing = 0; forced = 0; grant = 0;
        e_rdy = 0; e_we = 0; e_wd = 0; e_addr = 0;
        if (!rst) begin
            clearing = (m_clr_left > 0);
            forced   = GUARD && !clearing && (m_phase == 1) && (m_starve == LIMIT);
            e_rdy    = !clearing && !forced;
            grant    = !clearing && (m_phase == 1) && (forced || !draw_valid);
            if (clearing) begin
                e_we = 1; e_addr = m_clr_left - 1; e_wd = 0;
            end else if (!forced && draw_valid) begin
                e_we = 1; e_addr = int'(draw_addr); e_wd = draw_data;
            end else begin
                e_addr = m_ptr;
            end
        end
        check("draw_ready", 32'(draw_ready), 32'(e_rdy));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (rst || e_we) check("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        if (!rst) begin
            check("clear_busy", 32'(clear_busy), 32'(m_clr_left > 0));
            check("scan_busy", 32'(scan_busy), 32'(m_phase != 0));
            check("scan_valid", 32'(scan_valid), 32'(m_pend));
            check("scan_done", 32'(scan_done), 32'(m_pend && (m_pend_addr == N - 1)));
            if (m_pend) begin
                check("scan_addr", 32'(scan_addr), 32'(m_pend_addr));
                check("scan_data", 32'(scan_data), 32'(m_pend_data));
            end
        end
        last_accept = !rst && e_rdy && draw_valid;
        if (rst) begin
            m_clr_left = 0; m_phase = 0; m_ptr = 0; m_starve = 0; m_pend = 0;
        end else begin
            m_pend = grant;
            if (grant) begin
                m_pend_addr = m_ptr;
                m_pend_data = gold[m_ptr];
            end
            if (clearing) gold[m_clr_left - 1] = 0;
            else if (!forced && draw_valid) gold[int'(draw_addr)] = draw_data;
            if (m_phase == 1 && !clearing) m_starve = grant ? 0 : m_starve + 1;
            if (m_phase == 2) begin
                m_phase = 0;
            end else if (m_phase == 1) begin
                if (grant) begin
                    if (m_ptr == N - 1) m_phase = 2;
                    m_ptr = (m_ptr + 1) % N;
                end
            end else if (scan_start) begin
                m_ptr = 0;
                m_phase = 1;
            end
            if (clear_req) m_clr_left = N;
            else if (clearing) m_clr_left--;
        end
        @(posedge clk);
        @(negedge clk);
        clear_req = 0;
        scan_start = 0;
    endtask

    // Runs until scan_done is seen or the budget expires; returns beats and the done cycle.
    task automatic run_to_done(input int budget, output int beats, output int ones, output int done_cyc);
        beats = 0; ones = 0; done_cyc = -1;
        for (int k = 1; k <= budget && done_cyc < 0; k++) begin
            if (scan_valid) begin
                beats++;
                ones += int'(scan_data);
            end
            if (scan_done) done_cyc = k;
            tick();
        end
    endtask

    initial begin
        int busy, beats, ones, done_cyc, more, found;

        @(negedge clk);
        rst = 1;
        repeat (3) tick();
        rst = 0;
        #1;
        check("reset_clear_busy", 32'(clear_busy), 0);
        check("reset_scan_busy", 32'(scan_busy), 0);
        check("reset_scan_valid", 32'(scan_valid), 0);
        check("reset_scan_done", 32'(scan_done), 0);
        check("reset_scan_addr", 32'(scan_addr), 0);
        for (int i = 0; i < N; i++) gold[i] = ram[i];

        // Full clear with no other traffic.
        clear_req = 1;
        tick();
        busy = 0;
        for (int i = 0; i < 1030; i++) begin
            busy += int'(clear_busy);
            tick();
        end
        check("clear_busy_len", 32'(busy), 1024);
        ones = 0;
        for (int i = 0; i < N; i++) ones += int'(ram[i]);
        check("clear_ram_ones", 32'(ones), 0);

        // Set pixels 5 and 1023, then an uncontended scan.
        draw_valid = 1; draw_addr = 10'd5; draw_data = 1;
        tick();
        draw_addr = 10'd1023;
        tick();
        draw_valid = 0;
        tick();
        scan_start = 1;
        tick();
        run_to_done(1100, beats, ones, done_cyc);
        check("scan_beats", 32'(beats), 1024);
        check("scan_ones", 32'(ones), 2);
        check("scan_done_cycle", 32'(done_cyc), 1025);

        // Draw held at 0x2A3 while a scan is pending.
        scan_start = 1;
        draw_valid = 1; draw_addr = 10'h2A3; draw_data = 1;
        tick();
        beats = 0;
        for (int i = 0; i < 300; i++) begin
            beats += int'(scan_valid);
            tick();
        end
        check("contended_beats", 32'(beats), GUARD ? 4 : 0);
        draw_valid = 0;
        run_to_done(1200, more, ones, done_cyc);
        check("contended_total", 32'(beats + more), 1024);
        check("contended_done", 32'(done_cyc > 0), 1);

        // Clear arriving at scan beat 100.
        scan_start = 1;
        tick();
        beats = 0; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (scan_valid) begin
                beats++;
                if (scan_addr == 10'd100) found = 1;
            end
            if (!found) tick();
        end
        check("beat100_seen", 32'(found), 1);
        clear_req = 1;
        tick();
        run_to_done(2300, more, ones, done_cyc);
        check("clear_mid_scan_total", 32'(beats + more), 1024);
        check("clear_mid_scan_done", 32'(done_cyc > 0), 1);

        // Second clear request 10 cycles into a clear.
        clear_req = 1;
        tick();
        busy = 0;
        for (int i = 1; i <= 1100; i++) begin
            busy += int'(clear_busy);
            if (i == 10) clear_req = 1;
            tick();
        end
        check("restart_clear_len", 32'(busy), 1034);

        // Reset at scan beat 300, then a fresh scan starts from 0.
        scan_start = 1;
        tick();
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (scan_valid && scan_addr == 10'd300) found = 1;
            else tick();
        end
        check("beat300_seen", 32'(found), 1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        check("rst_scan_busy", 32'(scan_busy), 0);
        check("rst_scan_valid", 32'(scan_valid), 0);
        scan_start = 1;
        tick();
        found = 0;
        for (int i = 0; i < 5 && !found; i++) begin
            if (scan_valid) found = 1;
            else tick();
        end
        check("rescan_first_seen", 32'(found), 1);
        check("rescan_first_addr", 32'(scan_addr), 0);
        run_to_done(1100, beats, ones, done_cyc);
        check("rescan_done", 32'(done_cyc > 0), 1);

        // Clear and scan requested together: clear goes first, scan still completes.
        clear_req = 1; scan_start = 1;
        tick();
        check("both_clear_busy", 32'(clear_busy), 1);
        run_to_done(2200, beats, ones, done_cyc);
        check("both_scan_beats", 32'(beats), 1024);
        check("both_scan_ones", 32'(ones), 0);

        // Random traffic respecting the draw handshake.
        for (int i = 0; i < 4000; i++) begin
            if (!draw_valid || last_accept) begin
                draw_valid = 1'($urandom_range(0, 1));
                draw_addr  = 10'($urandom);
                draw_data  = 1'($urandom_range(0, 1));
            end
            clear_req  = ($urandom_range(0, 1999) == 0);
            scan_start = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
